// File: rtl/acq_timing_pkg.sv
// Shared types and helpers for the multi-channel acquisition timebase.
package acq_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int unsigned MIN_PERIOD = 2;

  // LSB index of channel k inside a flat bus of w-bit fields.
  function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/acq_period_ctr.sv
// One acquisition channel: shadow/active period, clamp with sticky error, frame-aligned counter.
module acq_period_ctr
  import acq_timing_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEF_PERIOD = 100_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_frame,
  input  logic             i_reload,
  input  logic             i_en,
  input  logic             i_ld,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_pulse,
  output logic             o_cfg_err
);

  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] r_cc;
  logic [CNT_W-1:0] w_cc;
  logic             r_cfg_err;
  logic             w_illegal;

  assign w_illegal = (i_period < CNT_W'(MIN_PERIOD));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow  <= CNT_W'(DEF_PERIOD);
      r_cfg_err <= 1'b0;
    end else if (i_ld) begin
      r_shadow <= w_illegal ? CNT_W'(MIN_PERIOD) : i_period;
      if (w_illegal) r_cfg_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active <= CNT_W'(DEF_PERIOD);
    end else if (i_reload) begin
      r_active <= r_shadow;
    end
  end

  // The frame pulse truncates any partial period: the count seen this cycle is 0.
  assign w_cc = i_frame ? '0 : r_cc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cc <= '0;
    end else if (!i_run) begin
      r_cc <= '0;
    end else if (w_cc == (r_active - CNT_W'(1))) begin
      r_cc <= '0;
    end else begin
      r_cc <= w_cc + CNT_W'(1);
    end
  end

  assign o_pulse   = i_run & i_en & (w_cc == '0);
  assign o_cfg_err = r_cfg_err;

endmodule

// File: rtl/acq_timebase_mc.sv
// Multi-channel acquisition timebase: start sync, blank window, frame pulses, per-channel pulses.
module acq_timebase_mc
  import acq_timing_pkg::*;
#(
  parameter int unsigned CH_NUM       = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned BLANK_CYCLES = 1_000_000,
  parameter int unsigned FRAME_CYCLES = 2_500_000,
  parameter int unsigned DEF_PERIOD   = 100_000
) (
  input  logic                    sys_clk_i,
  input  logic                    rst_i,
  input  logic                    gpio_start_trigger_i,
  input  logic                    stop_i,
  input  logic [CH_NUM-1:0]       ch_en_i,
  input  logic [CH_NUM*CNT_W-1:0] ch_period_i,
  input  logic                    ch_period_ld_i,
  output logic                    blank_window_o,
  output logic                    frame_pulse_o,
  output logic [CH_NUM-1:0]       ch_pulse_o,
  output logic [31:0]             frame_cnt_o,
  output logic                    running_o,
  output logic [CH_NUM-1:0]       cfg_err_o
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync2_d;
  logic             r_edge;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_bc;
  logic [CNT_W-1:0] r_fc;
  logic [31:0]      r_frame_cnt;
  logic             w_blank_entry;
  logic             w_blank_done;
  logic             w_frame;
  logic             w_run;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
      r_edge    <= 1'b0;
    end else begin
      r_sync1   <= gpio_start_trigger_i;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
      r_edge    <= r_sync2 & ~r_sync2_d;
    end
  end

  assign w_run         = (r_state == ST_RUN);
  assign w_blank_entry = (r_state == ST_IDLE) & r_edge & ~stop_i;
  assign w_blank_done  = (r_bc == CNT_W'(BLANK_CYCLES - 1));
  assign w_frame       = w_run & (r_fc == '0);

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (stop_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (r_edge) w_state_nxt = ST_BLANK;
        ST_BLANK: if (w_blank_done) w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bc <= '0;
    end else if ((r_state == ST_BLANK) && (w_state_nxt == ST_BLANK)) begin
      r_bc <= r_bc + CNT_W'(1);
    end else begin
      r_bc <= '0;
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fc <= '0;
    end else if (w_run && (w_state_nxt == ST_RUN)) begin
      r_fc <= (r_fc == CNT_W'(FRAME_CYCLES - 1)) ? '0 : r_fc + CNT_W'(1);
    end else begin
      r_fc <= '0;
    end
  end

  // Held across stop so software can read it; cleared only when a new start is accepted.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_frame_cnt <= '0;
    end else if (w_blank_entry) begin
      r_frame_cnt <= '0;
    end else if (w_frame) begin
      r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    acq_period_ctr #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_ctr (
      .i_clk     (sys_clk_i),
      .i_rst     (rst_i),
      .i_run     (w_run),
      .i_frame   (w_frame),
      .i_reload  (w_frame | w_blank_entry),
      .i_en      (ch_en_i[k]),
      .i_ld      (ch_period_ld_i),
      .i_period  (ch_period_i[ch_lsb(k, CNT_W) +: CNT_W]),
      .o_pulse   (ch_pulse_o[k]),
      .o_cfg_err (cfg_err_o[k])
    );
  end

  assign blank_window_o = (r_state == ST_BLANK);
  assign frame_pulse_o  = w_frame;
  assign running_o      = (r_state != ST_IDLE);
  assign frame_cnt_o    = r_frame_cnt;

endmodule

// File: tb/tb_acq_timebase_mc.sv
// Directed bench for acq_timebase_mc with small timing parameters.
module tb_acq_timebase_mc;

  localparam int unsigned CH_NUM = 2;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned NONE   = 9999;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    gpio;
  logic                    stop_i;
  logic [CH_NUM-1:0]       ch_en;
  logic [CH_NUM*CNT_W-1:0] ch_period;
  logic                    ch_ld;
  logic                    blank_window;
  logic                    frame_pulse;
  logic [CH_NUM-1:0]       ch_pulse;
  logic [31:0]             frame_cnt;
  logic                    running;
  logic [CH_NUM-1:0]       cfg_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  acq_timebase_mc #(
    .CH_NUM       (CH_NUM),
    .CNT_W        (CNT_W),
    .BLANK_CYCLES (10),
    .FRAME_CYCLES (100),
    .DEF_PERIOD   (10)
  ) dut (
    .sys_clk_i            (clk),
    .rst_i                (rst),
    .gpio_start_trigger_i (gpio),
    .stop_i               (stop_i),
    .ch_en_i              (ch_en),
    .ch_period_i          (ch_period),
    .ch_period_ld_i       (ch_ld),
    .blank_window_o       (blank_window),
    .frame_pulse_o        (frame_pulse),
    .ch_pulse_o           (ch_pulse),
    .frame_cnt_o          (frame_cnt),
    .running_o            (running),
    .cfg_err_o            (cfg_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_blank"}, blank_window, 0);
    chk({tag, "_frame"}, frame_pulse, 0);
    chk({tag, "_ch"}, ch_pulse, 0);
    chk({tag, "_run"}, running, 0);
  endtask

  // Trigger rise, then 3 idle cycles and exactly 10 blank cycles; returns at the last blank cycle.
  task automatic start();
    gpio = 1'b0;
    repeat (4) @(negedge clk);
    gpio = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat_blank", blank_window, 0);
      chk("lat_run", running, 0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("blank_hi", blank_window, 1);
      chk("blank_run", running, 1);
      chk("blank_frame", frame_pulse, 0);
      chk("blank_ch", ch_pulse, 0);
      if (i == 0) chk("blank_fcnt", frame_cnt, 0);
    end
  endtask

  task automatic frame(input int unsigned p0, input int unsigned p1, input logic [1:0] en,
                       input int unsigned fno, input int unsigned ncyc,
                       input int unsigned ld_at, input logic [63:0] ld_val,
                       input int unsigned stop_at);
    for (int unsigned o = 0; o < ncyc; o++) begin
      @(negedge clk);
      ch_ld  = 1'b0;
      stop_i = 1'b0;
      chk("frame_pulse", frame_pulse, (o == 0));
      chk("ch_pulse", ch_pulse, {en[1] && (o % p1 == 0), en[0] && (o % p0 == 0)});
      chk("run_blank", blank_window, 0);
      if (o == 1) chk("frame_cnt", frame_cnt, fno);
      if (o == ld_at) begin
        ch_period = ld_val;
        ch_ld     = 1'b1;
      end
      if (o == stop_at) stop_i = 1'b1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    gpio      = 1'b0;
    stop_i    = 1'b0;
    ch_en     = 2'b11;
    ch_period = '0;
    ch_ld     = 1'b0;

    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk("reset_fcnt", frame_cnt, 0);
    chk("reset_err", cfg_err, 0);
    rst = 1'b0;

    @(negedge clk);
    ch_period = {32'd25, 32'd10};
    ch_ld     = 1'b1;
    @(negedge clk);
    ch_ld = 1'b0;
    chk("idle_quiet_run", running, 0);

    start();
    frame(10, 25, 2'b11, 1, 100, NONE, '0, NONE);
    frame(10, 25, 2'b11, 2, 100, 50, {32'd30, 32'd10}, NONE);
    frame(10, 30, 2'b11, 3, 100, 35, {32'd30, 32'd20}, NONE);
    frame(20, 30, 2'b11, 4, 100, 0, {32'd1, 32'd20}, NONE);
    chk("cfg_err_set", cfg_err, 2'b10);
    frame(20, 2, 2'b11, 5, 100, NONE, '0, NONE);
    ch_en = 2'b01;
    frame(20, 2, 2'b01, 6, 100, NONE, '0, NONE);
    ch_en = 2'b11;
    frame(20, 2, 2'b11, 7, 51, NONE, '0, 50);

    @(negedge clk);
    stop_i = 1'b0;
    chk("stop_fcnt_hold", frame_cnt, 7);
    for (int i = 0; i < 60; i++) begin
      chk_quiet("after_stop");
      @(negedge clk);
    end

    gpio = 1'b0;
    repeat (4) @(negedge clk);
    gpio = 1'b1;
    repeat (3) @(negedge clk);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_quiet("stop_vs_trig");
      chk("stop_vs_trig_fcnt", frame_cnt, 7);
      @(negedge clk);
    end

    start();
    frame(20, 2, 2'b11, 1, 30, NONE, '0, NONE);
    chk("cfg_err_sticky", cfg_err, 2'b10);

    #2 rst = 1'b1;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_fcnt", frame_cnt, 0);
    chk("async_rst_err", cfg_err, 0);
    @(negedge clk);
    rst = 1'b0;

    start();
    frame(10, 10, 2'b11, 1, 100, NONE, '0, NONE);
    chk("post_rst_err", cfg_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
